cr_fifo_wrap3: RTL and testbench

Parametrised single-clock FIFO wrapper, successor to the fixed 83-bit wrapper. Width and depth are parameters, and storage is built in. Almost-full and almost-empty thresholds are programmable at run time. The block adds a synchronous clear, overflow/underflow event pulses and an optional high-water-mark counter. It sits between producer and consumer pipeline stages in the compression datapath.

---
 rtl/cr_fifo_pkg.sv | 15 +
 rtl/cr_fifo_wrap3_mem.sv | 31 +++
 rtl/cr_fifo_wrap3.sv | 121 ++++++++++++
 tb/tb_cr_fifo_wrap3.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cr_fifo_pkg.sv
// Shared FIFO helpers: count-width derivation and pointer increment with wrap.
// Used by cr_fifo_wrap3 and later FIFO variants.
package cr_fifo_pkg;

  // Width needed to hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Next pointer value; wraps from depth-1 back to 0 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cr_fifo_wrap3_mem.sv
// DEPTH x DATA_W flop array for cr_fifo_wrap3: one write port, asynchronous read.
// The array resets to zero so rdata is X-free from reset onward.
module cr_fifo_wrap3_mem #(
  parameter int DATA_W = 83,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cr_fifo_wrap3.sv
// Parametrised single-clock FIFO with programmable almost-full/empty, sync clear,
// overflow/underflow pulses. The high-water-mark port exists only with CR_FIFO_HWM_EN.
module cr_fifo_wrap3
  import cr_fifo_pkg::*;
#(
  parameter  int DATA_W = 83,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  input  logic [CNT_W-1:0]  afull_th,
  input  logic [CNT_W-1:0]  aempty_th,
  output logic [CNT_W-1:0]  used_slots,
  output logic [CNT_W-1:0]  free_slots,
  output logic              overflow,
  output logic              underflow
`ifdef CR_FIFO_HWM_EN
  ,
  output logic [CNT_W-1:0]  hwm
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [CNT_W-1:0] used_next;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_inc;

  // Acceptance is judged on the registered flags, so a write at full is dropped
  // even when a read frees a slot in the same cycle, and there is no empty bypass.
  always_comb begin
    wr_acc     = wen && !full;
    rd_acc     = ren && !empty;
    used_next  = used_slots + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    wr_ptr_inc = PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
    rd_ptr_inc = PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
  end

  cr_fifo_wrap3_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc && !clear),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used_slots <= '0;
      free_slots <= DEPTH_C;
      full       <= 1'b0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      aempty     <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used_slots <= '0;
      free_slots <= DEPTH_C;
      full       <= 1'b0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      aempty     <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr_inc;
      end
      used_slots <= used_next;
      free_slots <= DEPTH_C - used_next;
      full       <= (used_next == DEPTH_C);
      empty      <= (used_next == '0);
      afull      <= (used_next >= afull_th);
      aempty     <= (used_next <= aempty_th);
      overflow   <= wen && full;
      underflow  <= ren && empty;
    end
  end

`ifdef CR_FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else if (clear) begin
      hwm <= '0;
    end else if (used_next > hwm) begin
      hwm <= used_next;
    end
  end
`endif

endmodule

// File: tb/tb_cr_fifo_wrap3.sv
// Scoreboard bench for cr_fifo_wrap3 (DEPTH=16, DATA_W=83); hwm checked when
// CR_FIFO_HWM_EN is defined.
module tb_cr_fifo_wrap3;

  localparam int DW    = 83;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic [DW-1:0] rdata;
  logic          full, empty, afull, aempty, overflow, underflow;
  logic [CW-1:0] afull_th = CW'(14);
  logic [CW-1:0] aempty_th = CW'(2);
  logic [CW-1:0] used_slots, free_slots;
`ifdef CR_FIFO_HWM_EN
  logic [CW-1:0] hwm;
`endif

  cr_fifo_wrap3 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wen        (wen),
    .wdata      (wdata),
    .ren        (ren),
    .rdata      (rdata),
    .full       (full),
    .empty      (empty),
    .afull      (afull),
    .aempty     (aempty),
    .afull_th   (afull_th),
    .aempty_th  (aempty_th),
    .used_slots (used_slots),
    .free_slots (free_slots),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef CR_FIFO_HWM_EN
    ,
    .hwm        (hwm)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // reference model: contents queue plus expected status after the last edge
  logic [DW-1:0] sb_q[$];
  int m_used, m_hwm;
  bit m_ovf, m_unf, m_afull, m_aempty;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_used = 0; m_hwm = 0;
    m_ovf = 0; m_unf = 0; m_afull = 0; m_aempty = 1;
  endtask

  // Called at posedge+1: drive one cycle, then advance the model across the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int ath, eth;
    bit wa, ra;
    wen = w; wdata = d; ren = r; clear = c;
    ath = int'(afull_th);
    eth = int'(aempty_th);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      wa = w && (m_used != DEPTH);
      ra = r && (m_used != 0);
      m_ovf = w && !wa;
      m_unf = r && !ra;
      if (wa) sb_q.push_back(d);
      m_used = m_used + int'(wa) - int'(ra);
      m_afull = (m_used >= ath);
      m_aempty = (m_used <= eth);
      if (m_used > m_hwm) m_hwm = m_used;
    end
    wen = 0; ren = 0; clear = 0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // monitor: status against model every cycle, data popped on each accepted read
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("used_slots", used_slots, m_used);
        chk("free_slots", free_slots, DEPTH - m_used);
        chk("full", full, m_used == DEPTH);
        chk("empty", empty, m_used == 0);
        chk("afull", afull, m_afull);
        chk("aempty", aempty, m_aempty);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
`ifdef CR_FIFO_HWM_EN
        chk("hwm", hwm, m_hwm);
`endif
        if (ren && !empty && !clear) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_pop: read accepted but model holds no entries at %0t", $time);
          end else begin
            chk("rdata", rdata, sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) step(0, '0, 0, 0);

    // fill 0..15 then one write too many
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 0);
    step(1, DW'(16), 0, 0);
    step(0, '0, 0, 0);

    // write+read at full: head 0 consumed, write dropped
    step(1, DW'('h99), 1, 0);
    step(0, '0, 0, 0);

    // drain and read once more on empty
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // write+read on empty: no bypass
    step(1, DW'('habc), 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // fill to 10 then clear with a concurrent write
    step(0, '0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, rand_word(), 0, 0);
    step(1, rand_word(), 0, 1);
    step(0, '0, 0, 0);

    // interleaved write/read across pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1, rand_word(), 0, 0);
      step(0, '0, 1, 0);
    end

    // random traffic with threshold changes and occasional clear
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        afull_th = CW'($urandom_range(0, DEPTH + 1));
        aempty_th = CW'($urandom_range(0, DEPTH + 1));
      end
      step($urandom_range(0, 99) < 55, rand_word(), $urandom_range(0, 99) < 45,
           $urandom_range(0, 63) == 0);
    end
    afull_th = CW'(14);
    aempty_th = CW'(2);

    // asynchronous reset with five entries held
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, rand_word(), 0, 0);
    chk("pre_reset_used", used_slots, 5);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_used", used_slots, 0);
    chk("rst_free", free_slots, DEPTH);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_rdata", rdata, 0);
`ifdef CR_FIFO_HWM_EN
    chk("rst_hwm", hwm, 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) step(0, '0, 0, 0);
    step(1, DW'('h5a5a), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
